// File: rtl/mul_div_pkg.sv
// -----------------------------------------------------------------------------
// mul_div_pkg
// Shared definitions for the multi-cycle multiply/divide unit:
//   - op encodings (op[1] selects divide, op[0] selects signed)
//   - FSM state encoding
//   - default operand / HI / LO width
// -----------------------------------------------------------------------------
package mul_div_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// -----------------------------------------------------------------------------
// mul_div_if
// Bundle between the execute-stage control/datapath and mul_div_unit.
//   start, op, a, b      : operation request (rs/rt operands, decoded op)
//   wr_hi, wr_lo, wdata  : mthi / mtlo writes
//   busy, done, hi, lo   : status and architectural HI/LO
// master = execute stage side, slave = mul_div_unit.
// -----------------------------------------------------------------------------
interface mul_div_if #(
  parameter int WIDTH = mul_div_pkg::WIDTH_DEF
) ();

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, wr_hi, wr_lo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, wr_hi, wr_lo, wdata,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mul_div_unit_abs_negate.sv
// -----------------------------------------------------------------------------
// abs_negate
// Conditional two's-complement negate. Used to form operand magnitudes
// (neg_i = operand sign) and to restore result signs.
//   val_i : input value
//   neg_i : 1 = output -val_i, 0 = pass through
//   val_o : result
// -----------------------------------------------------------------------------
module abs_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + {{(W-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Multiply is shift-add, divide is restoring; both take WIDTH CALC cycles,
// followed by one FIX cycle that commits HI/LO and pulses done.
//
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high; aborts any operation, clears HI/LO
//   bus   : mul_div_if.slave (start/op/a/b, wr_hi/wr_lo/wdata,
//           busy/done/hi/lo)
//
// Build option: define MULDIV_SIGNED_EN to honour op[0] (signed MULT/DIV).
// Without it every op is unsigned and FIX is a plain commit.
// -----------------------------------------------------------------------------
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic       clk,
  input  logic       reset,
  mul_div_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  // acc holds {partial product, multiplier} for multiply and
  // {partial remainder, dividend/quotient} for divide.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  // Multiplicand (multiply) or divisor (divide) magnitude.
  logic [WIDTH-1:0]     mcd_q, mcd_d;
  logic                 is_div_q, is_div_d;
  logic                 dz_q, dz_d;
  logic [WIDTH-1:0]     araw_q, araw_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   prod_res;
  logic [WIDTH-1:0]     quo_res, rem_res;

  logic                 accept;
  assign accept = (state_q == S_IDLE) && bus.start;

`ifdef MULDIV_SIGNED_EN
  logic op_signed;
  logic negq_q;   // quotient / product sign
  logic negr_q;   // remainder sign (follows the dividend)

  assign op_signed = bus.op[0];

  abs_negate #(.W(WIDTH)) u_abs_a (
    .val_i (bus.a),
    .neg_i (op_signed & bus.a[WIDTH-1]),
    .val_o (a_mag)
  );

  abs_negate #(.W(WIDTH)) u_abs_b (
    .val_i (bus.b),
    .neg_i (op_signed & bus.b[WIDTH-1]),
    .val_o (b_mag)
  );

  abs_negate #(.W(2*WIDTH)) u_neg_prod (
    .val_i (acc_q),
    .neg_i (negq_q),
    .val_o (prod_res)
  );

  abs_negate #(.W(WIDTH)) u_neg_quo (
    .val_i (acc_q[WIDTH-1:0]),
    .neg_i (negq_q),
    .val_o (quo_res)
  );

  abs_negate #(.W(WIDTH)) u_neg_rem (
    .val_i (acc_q[2*WIDTH-1:WIDTH]),
    .neg_i (negr_q),
    .val_o (rem_res)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      negq_q <= op_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      negr_q <= op_signed & bus.a[WIDTH-1];
    end
  end
`else
  logic unused_op_signed;
  assign unused_op_signed = bus.op[0];

  assign a_mag    = bus.a;
  assign b_mag    = bus.b;
  assign prod_res = acc_q;
  assign quo_res  = acc_q[WIDTH-1:0];
  assign rem_res  = acc_q[2*WIDTH-1:WIDTH];
`endif

  // Shift-add step: add multiplicand to the upper half when the current
  // multiplier bit (acc[0]) is set, then shift the whole accumulator right
  // with the carry entering at the top.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, mcd_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring step: shift the next dividend bit into the remainder, try to
  // subtract the divisor; a clear borrow bit means the subtraction stands.
  logic [WIDTH:0]       div_shift, div_trial;
  logic                 div_ok;
  logic [WIDTH-1:0]     rem_new;
  logic [2*WIDTH-1:0]   div_next;
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, mcd_q};
  assign div_ok    = ~div_trial[WIDTH];
  assign rem_new   = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_next  = {rem_new, acc_q[WIDTH-2:0], div_ok};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    acc_d    = acc_q;
    mcd_d    = mcd_q;
    is_div_d = is_div_q;
    dz_d     = dz_q;
    araw_d   = araw_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.wr_hi) hi_d = bus.wdata;
        if (bus.wr_lo) lo_d = bus.wdata;
        if (bus.start) begin
          is_div_d = bus.op[1];
          dz_d     = (bus.b == '0);
          araw_d   = bus.a;
          cnt_d    = CNT_W'(WIDTH);
          if (bus.op[1]) begin
            mcd_d = b_mag;
            acc_d = {{WIDTH{1'b0}}, a_mag};
          end else begin
            mcd_d = a_mag;
            acc_d = {{WIDTH{1'b0}}, b_mag};
          end
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end

      S_FIX: begin
        if (is_div_q) begin
          if (dz_q) begin
            // Divide by zero: HI gets the raw dividend, LO all ones.
            hi_d = araw_q;
            lo_d = '1;
          end else begin
            hi_d = rem_res;
            lo_d = quo_res;
          end
        end else begin
          {hi_d, lo_d} = prod_res;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    mcd_q    <= mcd_d;
    is_div_q <= is_div_d;
    dz_q     <= dz_d;
    araw_q   <= araw_d;
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle multiply/divide unit owning the architectural HI/LO registers. Sits beside the ALU in the execute stage. It consumes the two register-file read operands (rs, rt) and the decoded op. It produces HI/LO for the mfhi/mflo result path and a busy stall that the control path uses to hold the program counter and suppress mfhi/mflo until the result is committed.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin operation; sampled only in IDLE
- op  in  2  op[1]: 0 = multiply, 1 = divide; op[0]: 1 = signed
- a  in  WIDTH  rs operand (multiplicand / dividend)
- b  in  WIDTH  rt operand (multiplier / divisor)
- wr_hi  in  1  mthi: load wdata into HI
- wr_lo  in  1  mtlo: load wdata into LO
- wdata  in  WIDTH  mthi/mtlo data
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse; HI/LO hold the new result
- hi  out  WIDTH  HI register (product upper half / remainder)
- lo  out  WIDTH  LO register (product lower half / quotient)

## Operation
- FSM states: IDLE, CALC, FIX.
- IDLE + start: latch magnitudes of a and b, iteration counter = WIDTH, go to CALC. Unsigned ops use operands as-is. Signed ops take two's-complement absolute values and record result signs: quotient/product sign = a[msb]^b[msb], remainder sign = a[msb].
- CALC, multiply: shift-add, one multiplier bit per cycle, into a 2·WIDTH accumulator.
- CALC, divide: restoring, one quotient bit per cycle.
- CALC runs exactly WIDTH cycles, then goes to FIX.
- FIX: negate results per the recorded signs (signed ops only), write HI/LO, assert done, return to IDLE.
- Division by zero: HI = a (unmodified input), LO = all ones, for both DIV and DIVU. No exception.
- DIV of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0. This is the natural magnitude result; no special trap.
- wr_hi/wr_lo take effect only in IDLE and are ignored while busy. If a write coincides with start, the write is applied and the later result overwrites it.
- start while busy is ignored. No queueing.
- HI/LO change only on wr_hi/wr_lo, on FIX, or on reset.

## Timing
- Reset values: state IDLE, busy 0, done 0, hi 0, lo 0.
- Edge 0: start accepted. busy = 1 from the cycle after edge 0.
- Edges 1..WIDTH: CALC iterations.
- Edge WIDTH+1: FIX commits HI/LO. During the following cycle busy = 0, done = 1, and hi/lo show the result.
- Start-to-done latency: WIDTH+2 cycles. busy is high for WIDTH+1 cycles.
- A new start may be accepted in the same cycle done is high.
- busy is driven directly from state (registered). No combinational path from start to busy.
- Reset mid-operation aborts immediately: the next cycle is IDLE with busy 0, done 0, HI/LO 0.

## Configuration
- MULDIV_SIGNED_EN defined: op[0] is honoured; the absolute-value and negation logic is present.
- MULDIV_SIGNED_EN undefined: op[0] is ignored, all ops are unsigned, and the negation logic is removed. Latency is unchanged; FIX still runs, as a pure commit.

## Structure
- Shared package mul_div_pkg holds:
  - op encodings: OP_MULTU = 2'b00, OP_MULT = 2'b01, OP_DIVU = 2'b10, OP_DIV = 2'b11
  - FSM state encoding
  - default WIDTH constant
- One sub-module, abs_negate: conditional two's-complement negate, used for operand magnitudes and for result sign fixup. Instantiated only under MULDIV_SIGNED_EN.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001; done exactly 34 cycles after start (WIDTH = 32).
- MULT −3 × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. Without MULDIV_SIGNED_EN: HI = 0x00000006, LO = 0xFFFFFFEB.
- DIVU 100 / 7 → LO = 14, HI = 2. DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 5 / 0 → HI = 5, LO = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- start and wr_hi (wdata = 0x1234) pulsed mid-operation → both ignored; final HI/LO equal the original op's result. wr_lo in IDLE → LO = wdata the next cycle, with no done pulse.
- reset asserted at cycle 10 of CALC → next cycle busy = 0, done = 0, HI = LO = 0. A new MULTU 3 × 4 then gives LO = 12, HI = 0.
